// File: rtl/tw_core.sv
// tw_core: TD4-style 4-bit-lineage core with fetch handshake, user/priv banks, level IRQ and TRAP/RETI
module tw_core #(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 4,
    parameter int TRAP_VEC = 12
) (
    input  logic                clock_i,
    input  logic                reset_i,
    output logic                instr_req_o,
    output logic [ADDR_W-1:0]   instr_addr_o,
    input  logic                instr_valid_i,
    input  logic [DATA_W+3:0]   instr_data_i,
    input  logic [DATA_W-1:0]   in_i,
    output logic [DATA_W-1:0]   out_o,
    input  logic                irq_i,
    output logic                priv_o
);
    typedef enum logic {FETCH, EXEC} state_t;
    state_t state_q, state_d;
    logic [DATA_W+3:0] ir_q, ir_d;
    logic [DATA_W-1:0] a_q [2], a_d [2], b_q [2], b_d [2];
    logic [1:0] c_q, c_d;
    logic [ADDR_W-1:0] pc_q, pc_d, epc_q, epc_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic priv_q, priv_d;
    logic [3:0] op;
    logic [DATA_W-1:0] imm;
    logic [DATA_W:0] sum_a, sum_b;
    logic [ADDR_W-1:0] pc_inc, imm_ext;
    logic bank;

    assign op      = ir_q[DATA_W+3:DATA_W];
    assign imm     = ir_q[DATA_W-1:0];
    assign bank    = priv_q;
    assign sum_a   = {1'b0, a_q[bank]} + {1'b0, imm};
    assign sum_b   = {1'b0, b_q[bank]} + {1'b0, imm};
    assign pc_inc  = pc_q + 1'b1;
    assign imm_ext = ADDR_W'(imm);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= FETCH;
            ir_q    <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            c_q     <= '0;
            pc_q    <= '0;
            epc_q   <= '0;
            out_q   <= '0;
            priv_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            out_q   <= out_d;
            priv_q  <= priv_d;
        end
    end

    always_comb begin
        state_d = state_q == FETCH ? (instr_valid_i ? EXEC : FETCH) : FETCH;
    end

    always_comb begin
        instr_req_o  = state_q == FETCH;
        instr_addr_o = pc_q;
        out_o        = out_q;
        priv_o       = priv_q;
    end

    always_comb begin
        ir_d   = (state_q == FETCH && instr_valid_i) ? instr_data_i : ir_q;
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        pc_d   = pc_q;
        epc_d  = epc_q;
        out_d  = out_q;
        priv_d = priv_q;
        if (state_q == EXEC) begin
            // A pending user-mode IRQ pre-empts the fetched instruction entirely
            if (irq_i && !priv_q) begin
                epc_d  = pc_q;
                priv_d = 1'b1;
                pc_d   = ADDR_W'(TRAP_VEC);
            end else begin
                pc_d      = pc_inc;
                c_d[bank] = 1'b0;
                case (op)
                    4'h0: {c_d[bank], a_d[bank]} = sum_a;
                    4'h1: a_d[bank] = b_q[bank];
                    4'h2: a_d[bank] = in_i;
                    4'h3: a_d[bank] = imm;
                    4'h4: b_d[bank] = a_q[bank];
                    4'h5: {c_d[bank], b_d[bank]} = sum_b;
                    4'h6: b_d[bank] = in_i;
                    4'h7: b_d[bank] = imm;
                    4'h8: begin
                        epc_d  = priv_q ? epc_q : pc_inc;
                        priv_d = 1'b1;
                        pc_d   = priv_q ? pc_inc : ADDR_W'(TRAP_VEC);
                    end
                    4'h9: out_d = b_q[bank];
                    4'hB: out_d = imm;
                    4'hC: begin
                        a_d[0] = priv_q ? a_q[1] : a_q[0];
                        a_d[1] = priv_q ? a_q[0] : a_q[1];
                    end
                    4'hD: begin
                        pc_d   = priv_q ? epc_q : pc_inc;
                        priv_d = 1'b0;
                    end
                    4'hE: pc_d = c_q[bank] ? pc_inc : imm_ext;
                    4'hF: pc_d = imm_ext;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tw_core.sv
// tb_tw_core: random instruction stream with variable fetch latency and IRQs, checked against an instruction-level model
module tb_tw_core;
    localparam int DW = 4;
    localparam int AW = 8;
    localparam int TV = 12;

    logic clk = 0, rst = 1;
    logic instr_req, instr_valid = 0, irq = 0, priv;
    logic [AW-1:0] instr_addr;
    logic [DW+3:0] instr_data = '0;
    logic [DW-1:0] in_v = '0, out;

    int npass = 0, ntot = 0;
    int ma [2], mb [2], mc [2];
    int mpc, mepc, mout, mpriv;

    tw_core #(.DATA_W(DW), .ADDR_W(AW), .TRAP_VEC(TV)) dut (
        .clock_i(clk), .reset_i(rst), .instr_req_o(instr_req), .instr_addr_o(instr_addr),
        .instr_valid_i(instr_valid), .instr_data_i(instr_data), .in_i(in_v), .out_o(out),
        .irq_i(irq), .priv_o(priv)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        ntot++;
        if (got == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    function automatic void mreset();
        for (int i = 0; i < 2; i++) begin ma[i] = 0; mb[i] = 0; mc[i] = 0; end
        mpc = 0; mepc = 0; mout = 0; mpriv = 0;
    endfunction

    // Architectural effect of one EXEC cycle, in plain integer arithmetic
    function automatic void mexec(input int op, input int imm, input int inv, input bit irqv);
        int p = mpriv, npc = (mpc + 1) % (1 << AW), s, t;
        if (irqv && p == 0) begin
            mepc = mpc; mpriv = 1; mpc = TV;
            return;
        end
        t = mc[p];
        mc[p] = 0;
        case (op)
            0: begin s = ma[p] + imm; ma[p] = s % 16; mc[p] = s / 16; end
            1: ma[p] = mb[p];
            2: ma[p] = inv;
            3: ma[p] = imm;
            4: mb[p] = ma[p];
            5: begin s = mb[p] + imm; mb[p] = s % 16; mc[p] = s / 16; end
            6: mb[p] = inv;
            7: mb[p] = imm;
            8: if (p == 0) begin mepc = npc; mpriv = 1; npc = TV; end
            9: mout = mb[p];
            11: mout = imm;
            12: if (p == 1) begin s = ma[0]; ma[0] = ma[1]; ma[1] = s; end
            13: if (p == 1) begin npc = mepc; mpriv = 0; end
            14: if (t == 0) npc = imm;
            15: npc = imm;
            default: ;
        endcase
        mpc = npc;
    endfunction

    task automatic step(input logic [7:0] ins, input int waits, input bit irqv, input logic [3:0] inv);
        int t = 0;
        @(negedge clk);
        while (!instr_req && t < 8) begin @(negedge clk); t++; end
        chk("fetch_req", int'(instr_req), 1);
        chk("addr", int'(instr_addr), mpc);
        chk("out", int'(out), mout);
        chk("priv", int'(priv), mpriv);
        for (int i = 0; i < waits; i++) begin
            instr_valid = 0;
            @(negedge clk);
            chk("hold_req", int'(instr_req), 1);
            chk("hold_addr", int'(instr_addr), mpc);
        end
        instr_valid = 1; instr_data = ins;
        @(negedge clk);
        instr_valid = 0; irq = irqv; in_v = inv;
        chk("exec_req", int'(instr_req), 0);
        mexec(int'(ins[7:4]), int'(ins[3:0]), int'(inv), irqv);
    endtask

    task automatic peek(input string nm, input int a, input int o, input int p);
        @(negedge clk);
        irq = 0;
        chk({nm, "_addr"}, int'(instr_addr), a);
        chk({nm, "_out"}, int'(out), o);
        chk({nm, "_priv"}, int'(priv), p);
    endtask

    initial begin
        mreset();
        repeat (2) @(negedge clk);
        rst = 0;
        // carry and JNC
        step(8'h39, 0, 0, 0); step(8'h08, 1, 0, 0); step(8'hE3, 0, 0, 0);
        peek("jnc_fall", 3, 0, 0);
        step(8'hE7, 0, 0, 0);
        peek("jnc_take", 7, 0, 0);
        step(8'h40, 0, 0, 0); step(8'h90, 2, 0, 0);
        peek("add_wrap", 9, 1, 0);
        // slow memory
        step(8'hB6, 3, 0, 0);
        peek("slow_out", 10, 6, 0);
        // IRQ pre-empts MOV B,7 at PC=2
        step(8'hF2, 0, 0, 0); step(8'h77, 0, 1, 0);
        peek("irq_entry", 12, 6, 1);
        step(8'hD0, 0, 0, 0);
        peek("reti", 2, 6, 0);
        step(8'h77, 0, 0, 0); step(8'h90, 0, 0, 0);
        peek("mov_b7", 4, 7, 0);
        // SWAP in priv and in user
        step(8'h35, 0, 0, 0); step(8'h80, 0, 0, 0); step(8'h33, 0, 0, 0); step(8'hC0, 1, 0, 0);
        step(8'h40, 0, 0, 0); step(8'h90, 0, 0, 0);
        peek("swap_priv", 16, 5, 1);
        step(8'hD0, 0, 0, 0); step(8'h40, 0, 0, 0); step(8'h90, 0, 0, 0);
        peek("swap_user", 8, 3, 0);
        step(8'hC0, 0, 0, 0); step(8'h40, 0, 0, 0); step(8'h90, 0, 0, 0);
        peek("swap_nop", 11, 3, 0);
        // PC wrap and TRAP at 0x20
        step(8'hFF, 0, 0, 0);
        while (mpc != 255) step(8'hA0, 0, 0, 0);
        step(8'hA0, 0, 0, 0);
        peek("pc_wrap", 0, 3, 0);
        while (mpc != 32) step(8'hA0, 0, 0, 0);
        step(8'h80, 0, 0, 0);
        peek("trap", 12, 3, 1);
        step(8'hD0, 0, 0, 0);
        peek("trap_ret", 33, 3, 0);
        // reset while a fetch is pending at PC=5
        step(8'hF5, 0, 0, 0);
        peek("pre_rst", 5, 3, 0);
        #2 rst = 1;
        #2 rst = 0;
        mreset();
        peek("post_rst", 0, 0, 0);
        chk("post_rst_req", int'(instr_req), 1);
        for (int n = 0; n < 800; n++)
            step(8'($urandom_range(0, 255)), $urandom_range(0, 3) * int'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
        peek("final", mpc, mout, mpriv);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
